// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : rst_seq_pkg
// Brief  : Shared types and constants for the reset sequencer: the FSM state
//          encoding and the width/saturation value of the lock-loss counter.
// Rev    : 1.0  initial release
// ============================================================================
package rst_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        RUN    = 2'd2,
        ASSERT = 2'd3
    } state_t;

    localparam int                        LOCKLOSS_CNT_W   = 8;
    localparam logic [LOCKLOSS_CNT_W-1:0] LOCKLOSS_CNT_MAX = 8'hFF;

endpackage : rst_seq_pkg
`default_nettype wire

// File: rtl/rst_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : rst_sequencer_if
// Brief  : Control/status bundle of the reset sequencer.
//          i_pllLocked   - PLL lock (asynchronous)
//          i_swRst       - software reset request (synchronous level)
//          o_rst         - per-stage active-high resets, bit 0 released first
//          o_ready       - all stages released and sequencer in RUN
//          o_lockLossCnt - saturating lock-loss event count
//          master: the side driving requests; slave: the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface rst_sequencer_if #(
    parameter int N_STAGE = 4
);
    import rst_seq_pkg::*;

    logic                      i_pllLocked;
    logic                      i_swRst;
    logic [N_STAGE-1:0]        o_rst;
    logic                      o_ready;
    logic [LOCKLOSS_CNT_W-1:0] o_lockLossCnt;

    modport master (
        output i_pllLocked,
        output i_swRst,
        input  o_rst,
        input  o_ready,
        input  o_lockLossCnt
    );

    modport slave (
        input  i_pllLocked,
        input  i_swRst,
        output o_rst,
        output o_ready,
        output o_lockLossCnt
    );

endinterface : rst_sequencer_if
`default_nettype wire

// File: rtl/rst_seq_sync.sv
`default_nettype none
// ============================================================================
// Module : rst_seq_sync
// Brief  : N_SYNC-deep flop chain bringing an asynchronous level into the
//          i_clk domain; clears to 0 on asynchronous reset.
//          i_clk   - destination clock
//          i_rstn  - asynchronous active-low reset
//          i_async - asynchronous input level
//          o_sync  - synchronised level (last flop of the chain)
// Rev    : 1.0  initial release
// ============================================================================
module rst_seq_sync #(
    parameter int N_SYNC = 2
) (
    input  wire logic i_clk,
    input  wire logic i_rstn,
    input  wire logic i_async,
    output logic      o_sync
);

    logic [N_SYNC-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[N_SYNC-2:0], i_async};
        end
    end

    assign o_sync = r_chain[N_SYNC-1];

endmodule : rst_seq_sync
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module : rst_sequencer
// Brief  : Releases N_STAGE resets in ascending order after PLL lock, spaced
//          HOLD_CYCLES apart; software request re-asserts them in descending
//          order; lock loss asserts all of them at once.
//          i_clk  - free-running sequencer clock
//          i_rstn - asynchronous active-low reset
//          bus    - rst_sequencer_if.slave (lock, sw request, resets, ready,
//                   lock-loss count)
//          Optional: RSTSEQ_LOCKLOSS_CNTR_EN builds the saturating lock-loss
//          counter; otherwise o_lockLossCnt is tied to zero.
// Rev    : 1.0  initial release
// ============================================================================
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_STAGE     = 4,
    parameter int HOLD_CYCLES = 256,
    parameter int N_SYNC      = 2,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  wire logic     i_clk,
    input  wire logic     i_rstn,
    rst_sequencer_if.slave bus
);

    // A single-stage build still needs a one-bit index register.
    localparam int              IDX_W         = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(N_STAGE - 1);
    localparam logic [CNT_W-1:0] C_CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t             r_state,  w_state_nxt;
    logic [IDX_W-1:0]   r_idx,    w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [N_STAGE-1:0] r_rst,    w_rst_nxt;
    logic               r_ready,  w_ready_nxt;
    logic               w_lock_s;

    rst_seq_sync #(
        .N_SYNC (N_SYNC)
    ) u_lock_sync (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_async (bus.i_pllLocked),
        .o_sync  (w_lock_s)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rst   <= '1;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rst   <= w_rst_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_rst_nxt   = r_rst;
        w_ready_nxt = r_ready;

        // Lock loss outranks both the software request and counter expiry.
        if ((r_state != IDLE) && !w_lock_s) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_rst_nxt   = '1;
            w_ready_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_rst_nxt   = '1;
                    w_ready_nxt = 1'b0;
                    if (w_lock_s && !bus.i_swRst) begin
                        w_cnt_nxt   = C_CNT_RELOAD;
                        w_idx_nxt   = '0;
                        w_state_nxt = COUNT;
                    end
                end
                COUNT: begin
                    if (r_cnt == '0) begin
                        w_rst_nxt[r_idx] = 1'b0;
                        if (r_idx == C_IDX_LAST) begin
                            w_state_nxt = RUN;
                            w_ready_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                            w_cnt_nxt = C_CNT_RELOAD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                RUN: begin
                    w_rst_nxt   = '0;
                    w_ready_nxt = 1'b1;
                    if (bus.i_swRst) begin
                        w_ready_nxt = 1'b0;
                        w_idx_nxt   = C_IDX_LAST;
                        w_state_nxt = ASSERT;
                    end
                end
                ASSERT: begin
                    w_rst_nxt[r_idx] = 1'b1;
                    if (r_idx == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt = r_idx - IDX_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                    w_rst_nxt   = '1;
                    w_ready_nxt = 1'b0;
                end
            endcase
        end
    end

`ifdef RSTSEQ_LOCKLOSS_CNTR_EN
    logic [LOCKLOSS_CNT_W-1:0] r_ll_cnt;
    logic                      w_ll_evt;

    assign w_ll_evt = (r_state != IDLE) && !w_lock_s;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ll_cnt <= '0;
        end else if (w_ll_evt && (r_ll_cnt != LOCKLOSS_CNT_MAX)) begin
            r_ll_cnt <= r_ll_cnt + LOCKLOSS_CNT_W'(1);
        end
    end

    assign bus.o_lockLossCnt = r_ll_cnt;
`else
    assign bus.o_lockLossCnt = '0;
`endif

    assign bus.o_rst   = r_rst;
    assign bus.o_ready = r_ready;

endmodule : rst_sequencer
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_rst_sequencer
// Brief  : Self-checking bench for rst_sequencer (N_STAGE=4, HOLD_CYCLES=4,
//          N_SYNC=2): vector table of per-edge expectations plus hand-written
//          async-reset and lock-loss saturation sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rst_sequencer;

`ifdef RSTSEQ_LOCKLOSS_CNTR_EN
    localparam int C_CNT_ON = 1;
`else
    localparam int C_CNT_ON = 0;
`endif

    typedef struct {
        logic       pll;
        logic       sw;
        int         n;      // edges to run with these inputs
        logic [3:0] rst;    // expected o_rst after each of those edges
        logic       ready;
        int         ll;     // lock-loss events seen so far
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    rst_sequencer_if #(.N_STAGE(4)) bus ();

    rst_sequencer #(
        .N_STAGE     (4),
        .HOLD_CYCLES (4),
        .N_SYNC      (2)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [3:0] r, input logic rdy, input int ll);
        int e;
        e = (ll > 255) ? 255 : ll;
        chk({nm, ".rst"},   32'(bus.o_rst), 32'(r));
        chk({nm, ".ready"}, 32'(bus.o_ready), 32'(rdy));
        chk({nm, ".llcnt"}, 32'(bus.o_lockLossCnt), 32'(e * C_CNT_ON));
    endtask

    task automatic add(input logic p, input logic s, input int n,
                       input logic [3:0] r, input logic rdy, input int ll);
        vec_t v;
        v.pll = p; v.sw = s; v.n = n; v.rst = r; v.ready = rdy; v.ll = ll;
        tbl.push_back(v);
    endtask

    initial begin
        bus.i_pllLocked = 1'b0;
        bus.i_swRst     = 1'b0;

        // Power-up release: entry to COUNT at edge 3, releases at 7/11/15/19
        add(1, 0, 6, 4'hF, 0, 0);
        add(1, 0, 4, 4'hE, 0, 0);
        add(1, 0, 4, 4'hC, 0, 0);
        add(1, 0, 4, 4'h8, 0, 0);
        add(1, 0, 4, 4'h0, 1, 0);
        // One-cycle software request in RUN, descending re-assert
        add(1, 1, 1, 4'h0, 0, 0);
        add(1, 0, 1, 4'h8, 0, 0);
        add(1, 0, 1, 4'hC, 0, 0);
        add(1, 0, 1, 4'hE, 0, 0);
        add(1, 0, 1, 4'hF, 0, 0);
        // Resequence; drop lock while o_rst==1100
        add(1, 0, 4, 4'hF, 0, 0);
        add(1, 0, 4, 4'hE, 0, 0);
        add(1, 0, 1, 4'hC, 0, 0);
        add(0, 0, 2, 4'hC, 0, 0);
        add(0, 0, 1, 4'hF, 0, 1);
        add(0, 0, 3, 4'hF, 0, 1);   // unlocked IDLE: no further count
        // Re-lock restarts from stage 0
        add(1, 0, 6, 4'hF, 0, 1);
        add(1, 0, 4, 4'hE, 0, 1);
        add(1, 0, 4, 4'hC, 0, 1);
        add(1, 0, 4, 4'h8, 0, 1);
        add(1, 0, 2, 4'h0, 1, 1);
        // lockS falls in the same cycle as a software request in RUN
        add(0, 0, 2, 4'h0, 1, 1);
        add(0, 1, 1, 4'hF, 0, 2);
        add(0, 0, 3, 4'hF, 0, 2);
        // IDLE held by software request, then COUNT ignores it
        add(1, 1, 6, 4'hF, 0, 2);
        add(1, 0, 1, 4'hF, 0, 2);
        add(1, 1, 3, 4'hF, 0, 2);
        add(1, 1, 4, 4'hE, 0, 2);
        add(1, 1, 4, 4'hC, 0, 2);
        add(1, 1, 4, 4'h8, 0, 2);
        add(1, 1, 1, 4'h0, 1, 2);
        add(1, 1, 1, 4'h0, 0, 2);
        add(1, 0, 1, 4'h8, 0, 2);
        add(1, 0, 1, 4'hC, 0, 2);
        add(1, 0, 1, 4'hE, 0, 2);
        add(1, 0, 1, 4'hF, 0, 2);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 4'hF, 1'b0, 0);

        rstn            = 1'b1;
        bus.i_pllLocked = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.i_pllLocked = tbl[i].pll;
            bus.i_swRst     = tbl[i].sw;
            for (int j = 0; j < tbl[i].n; j++) begin
                step();
                chk_all($sformatf("vec%0d.%0d", i, j), tbl[i].rst, tbl[i].ready, tbl[i].ll);
            end
        end

        // Async reset mid-COUNT: sequencer left in IDLE, locked, sw low
        bus.i_pllLocked = 1'b1;
        bus.i_swRst     = 1'b0;
        repeat (5) step();
        chk_all("pre_arst", 4'hE, 1'b0, 2);
        #2;
        rstn = 1'b0;
        #1;
        chk_all("arst", 4'hF, 1'b0, 0);
        rstn = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            chk_all($sformatf("arst_hold%0d", j), 4'hF, 1'b0, 0);
        end
        step();
        chk_all("arst_rel0", 4'hE, 1'b0, 0);

        // 300 lock-loss events; counter saturates at 255
        for (int k = 0; k < 300; k++) begin
            bus.i_pllLocked = 1'b1;
            repeat (3) step();
            bus.i_pllLocked = 1'b0;
            repeat (3) step();
            if (k == 0)   chk_all("sat_first", 4'hF, 1'b0, 1);
            if (k == 253) chk_all("sat_254", 4'hF, 1'b0, 254);
            if (k == 254) chk_all("sat_255", 4'hF, 1'b0, 255);
        end
        chk_all("sat_end", 4'hF, 1'b0, 300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rst_sequencer
`default_nettype wire

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised successor to the single-stage PLL-lock reset and the fixed 8-bit PHY-reset hold counter.
- Produces N_STAGE active-high reset outputs, all in the i_clk domain. After PLL lock they release in ascending order, spaced HOLD_CYCLES apart.
- Software request re-asserts them in descending order. Lock loss asserts all of them at once.
- Sits beside the PLL in board tops; drives reset for fabric, PHY and subsystems.

Parameters:
- N_STAGE, 4, number of sequenced reset outputs (range 1..16).
- HOLD_CYCLES, 256, i_clk cycles between successive releases (>=1).
- N_SYNC, 2, synchroniser depth for i_pllLocked (>=2).
- CNT_W, $clog2(HOLD_CYCLES+1), hold counter width (derived; do not override).

Ports:
- i_clk  input  1  sequencer clock (free-running PLL output).
- i_rstn  input  1  asynchronous active-low reset.
- i_pllLocked  input  1  PLL lock, asynchronous to i_clk.
- i_swRst  input  1  synchronous software reset request, level-sensitive, sampled each cycle.
- o_rst  output  N_STAGE  per-stage active-high reset; bit 0 released first.
- o_ready  output  1  high when every o_rst bit is low and state==RUN.
- o_lockLossCnt  output  8  saturating count of lock-loss events (see Optional Feature).

Behaviour:
- Reset (i_rstn low, async): o_rst='1, o_ready=0, o_lockLossCnt=0, sync chain=0, state=IDLE, stage index=0, counter=0.
- All outputs are registered. i_pllLocked passes through an N_SYNC-flop chain; lockS is the chain output.
- State IDLE:
  - o_rst='1.
  - When lockS=1 and i_swRst=0: counter<=HOLD_CYCLES-1, index<=0, go to COUNT.
- State COUNT:
  - Counter decrements each cycle.
  - When counter==0: o_rst[index]<=0.
  - If index==N_STAGE-1, go to RUN and o_ready<=1 on that same edge.
  - Otherwise index++, reload counter, stay in COUNT.
- Release timing: with T0 = first cycle in COUNT, o_rst[k] falls at edge T0+(k+1)*HOLD_CYCLES.
- State RUN:
  - o_rst='0, o_ready=1.
  - i_swRst=1: o_ready<=0, index<=N_STAGE-1, go to ASSERT.
- State ASSERT:
  - Each cycle sets o_rst[index]<=1.
  - index==0: go to IDLE. Otherwise index--.
  - Bit N_STAGE-1 asserts first; all bits are high N_STAGE cycles after entry.
  - IDLE holds while i_swRst stays high, then resequences.
- Lock loss (lockS falling, i.e. lockS=0 in COUNT/RUN/ASSERT):
  - Highest priority; overrides i_swRst and counter expiry in the same cycle.
  - Next edge: o_rst='1, o_ready=0, state=IDLE, index=0.
  - o_lockLossCnt increments, saturating at 8'hFF.
- lockS=0 while in IDLE: no count.
- lockS glitch shorter than one i_clk: may be missed; no requirement.
- i_swRst in COUNT: ignored; sequencing completes, then ASSERT is entered from RUN if i_swRst is still high.
- N_STAGE==1 / HOLD_CYCLES==1: legal. With HOLD_CYCLES==1 the counter is always 0 and one stage releases per cycle.
- No output ever changes combinationally from any input.

Optional Feature:
- Macro: RSTSEQ_LOCKLOSS_CNTR_EN.
- Defined: o_lockLossCnt behaves as above.
- Undefined: counter register is not built; o_lockLossCnt is tied to 8'h00. Port list is unchanged.

Decomposition:
- Package rst_seq_pkg:
  - state enum (IDLE, COUNT, RUN, ASSERT), 2-bit encoding.
  - LOCKLOSS_CNT_W=8 and its saturation constant.
- One sub-module, rst_seq_sync: N_SYNC-deep synchroniser with async active-low reset to 0.
  - Reused for i_pllLocked; later usable for other asynchronous control inputs.

Test Plan:
- Power-up: N_STAGE=4, HOLD_CYCLES=4, N_SYNC=2; i_pllLocked rises at cycle 0 after i_rstn release.
  - o_rst=4'b1111 until edge 7.
  - Then 1110@7, 1100@11, 1000@15, 0000@19.
  - o_ready rises @19.
- Software reset: i_swRst high one cycle in RUN.
  - o_rst goes 1000, 1100, 1110, 1111 on successive edges.
  - IDLE, then the full release sequence repeats; o_ready=0 throughout.
- Lock loss mid-sequence: drop i_pllLocked when o_rst=4'b1100.
  - N_SYNC+1 edges later, o_rst=4'b1111 and o_lockLossCnt=1.
  - Re-lock restarts from stage 0.
- Simultaneous events: lockS falls in the same cycle that i_swRst=1 in RUN.
  - All bits assert at once (no staggered ASSERT); count increments.
- Saturation: 300 lock-loss events -> o_lockLossCnt=8'hFF.
  - Rebuild without RSTSEQ_LOCKLOSS_CNTR_EN -> o_lockLossCnt constantly 0.
- Async reset mid-COUNT: i_rstn low for 1 ns between edges.
  - o_rst=4'b1111 and o_ready=0 immediately (no clock edge needed).
  - Sequence restarts after i_rstn release.
